// File: rtl/binary2bcd_seq_ctrl.sv
// binary2bcd_seq_ctrl: sequential double-dabble binary-to-BCD converter with a start/done handshake.
// Define BIN2BCD_BLANK_EN to add the registered leading-zero blank_mask output.
module binary2bcd_seq_ctrl #(
  parameter int N_BITS   = 8,
  parameter int N_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_BITS-1:0]       in_binary,
  output logic                    busy,
  output logic                    done,
  output logic [4*N_DIGITS-1:0]   packed_bcd,
  output logic [8*N_DIGITS-1:0]   unpacked_bcd
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [N_DIGITS-1:0]     blank_mask
`endif
);
  localparam int W  = 4*N_DIGITS + N_BITS;
  localparam int CW = $clog2(N_BITS + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t                r_state, w_next;
  logic [W-1:0]          r_scratch, w_adj, w_shifted;
  logic [CW-1:0]         r_cnt;
  logic [4*N_DIGITS-1:0] w_digits;
  logic [8*N_DIGITS-1:0] w_unpacked;
  logic                  w_last;
  // Every digit field is corrected before the shift, not just the lowest one.
  for (genvar d = 0; d < N_DIGITS; d++) begin : g_dig
    assign w_adj[N_BITS+4*d +: 4] = (r_scratch[N_BITS+4*d +: 4] >= 4'd5) ?
                                    r_scratch[N_BITS+4*d +: 4] + 4'd3 :
                                    r_scratch[N_BITS+4*d +: 4];
    assign w_unpacked[8*d +: 8] = {4'd0, w_digits[4*d +: 4]};
  end
  assign w_adj[N_BITS-1:0] = r_scratch[N_BITS-1:0];
  assign w_shifted         = w_adj << 1;
  assign w_digits          = w_shifted[W-1:N_BITS];
  assign w_last            = (r_cnt == CW'(1));
  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && start)        w_next = SHIFT;
    else if (r_state == SHIFT && w_last) w_next = DONE;
    else if (r_state == DONE)            w_next = IDLE;
  end
  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scratch    <= '0;
      r_cnt        <= '0;
      packed_bcd   <= '0;
      unpacked_bcd <= '0;
    end else if (r_state == IDLE && start) begin
      r_scratch <= {{(4*N_DIGITS){1'b0}}, in_binary};
      r_cnt     <= CW'(N_BITS);
    end else if (r_state == SHIFT) begin
      r_scratch <= w_shifted;
      r_cnt     <= r_cnt - CW'(1);
      if (w_last) begin
        packed_bcd   <= w_digits;
        unpacked_bcd <= w_unpacked;
      end
    end
  end
`ifdef BIN2BCD_BLANK_EN
  logic [N_DIGITS-1:0] w_blank;
  // Digit k is blank when it and every higher digit are zero; units never blank.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_blank
    if (k == 0) begin : g_units
      assign w_blank[k] = 1'b0;
    end else begin : g_upper
      assign w_blank[k] = ~|w_digits[4*N_DIGITS-1:4*k];
    end
  end
  always_ff @(posedge clk)
    if (!rst_n)                         blank_mask <= '0;
    else if (r_state == SHIFT && w_last) blank_mask <= w_blank;
`endif
endmodule

// File: tb/tb_binary2bcd_seq_ctrl.sv
// tb_binary2bcd_seq_ctrl: randomized self-checking bench for binary2bcd_seq_ctrl against a decimal model.
module tb_binary2bcd_seq_ctrl;
  localparam int NB = 8;
  localparam int ND = 3;
  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [NB-1:0]   in_binary;
  logic            busy;
  logic            done;
  logic [4*ND-1:0] packed_bcd;
  logic [8*ND-1:0] unpacked_bcd;
`ifdef BIN2BCD_BLANK_EN
  logic [ND-1:0]   blank_mask;
`endif
  int n_tests = 0;
  int n_fail  = 0;

  binary2bcd_seq_ctrl #(.N_BITS(NB), .N_DIGITS(ND)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_binary(in_binary),
    .busy(busy), .done(done), .packed_bcd(packed_bcd), .unpacked_bcd(unpacked_bcd)
`ifdef BIN2BCD_BLANK_EN
    , .blank_mask(blank_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*ND-1:0] ref_packed(input int v);
    logic [4*ND-1:0] r;
    r = '0;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [8*ND-1:0] ref_unpacked(input int v);
    logic [8*ND-1:0] r;
    r = '0;
    for (int k = 0; k < ND; k++) begin
      r[8*k +: 8] = 8'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [ND-1:0] ref_blank(input int v);
    logic [ND-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 1; k < ND; k++) begin
      p = p * 10;
      r[k] = (v < p);
    end
    return r;
  endfunction

  task automatic check_result(input string tag, input int v);
    check({tag, "_packed"}, 32'(packed_bcd), 32'(ref_packed(v)));
    check({tag, "_unpacked"}, 32'(unpacked_bcd), 32'(ref_unpacked(v)));
`ifdef BIN2BCD_BLANK_EN
    check({tag, "_blank"}, 32'(blank_mask), 32'(ref_blank(v)));
`endif
  endtask

  // One full conversion; with noise, start/in_binary are scrambled while busy.
  task automatic run(input int v, input bit noise);
    int bc, dc, dpos, guard;
    @(negedge clk);
    start = 1'b1;
    in_binary = NB'(v);
    @(negedge clk);
    start = 1'b0;
    bc = 0; dc = 0; dpos = 0; guard = 0;
    while (busy && guard < 40) begin
      bc++;
      if (done) begin
        dc++;
        dpos = bc;
        check_result("run", v);
      end
      if (noise) begin
        start = 1'($urandom);
        in_binary = NB'($urandom);
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check("busy_len", 32'(bc), NB + 1);
    check("done_cnt", 32'(dc), 1);
    check("done_pos", 32'(dpos), NB + 1);
    check("busy_after", 32'(busy), 0);
    check_result("hold", v);
  endtask

  initial begin
    int q[$];
    int last_done, nshift, extra, exp_v;
    rst_n = 1'b0;
    start = 1'b0;
    in_binary = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check_result("rst", 0);
    check("rst_packed", 32'(packed_bcd), 0);
    rst_n = 1'b1;

    run(255, 1'b0);
    run(0, 1'b0);
    run(99, 1'b0);
    run(200, 1'b1);

    // Back-to-back with start held high: 99, then 7, then random values.
    q = {};
    last_done = -1;
    exp_v = 99;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) check("b2b_unexpected_done", 1, 0);
        else check_result("b2b", q.pop_front());
        if (last_done >= 0) check("b2b_period", 32'(c - last_done), NB + 2);
        last_done = c;
      end
      start = (c < 50);
      if (!busy && start) begin
        in_binary = NB'(exp_v);
        q.push_back(exp_v);
        exp_v = (exp_v == 99) ? 7 : int'($urandom_range(0, 255));
      end else begin
        in_binary = NB'($urandom);
      end
    end
    start = 1'b0;
    check("b2b_drain", 32'(q.size()), 0);

    // Abort with reset in the fourth SHIFT cycle.
    @(negedge clk);
    start = 1'b1;
    in_binary = 8'd128;
    @(negedge clk);
    start = 1'b0;
    nshift = 1;
    while (nshift < 4) begin
      @(negedge clk);
      nshift++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_packed", 32'(packed_bcd), 0);
    check("abort_unpacked", 32'(unpacked_bcd), 0);
    extra = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("abort_no_activity", 32'(extra), 0);
    run(42, 1'b0);

    for (int v = 0; v < (1 << NB); v++) run(v, 1'b0);
    for (int i = 0; i < 20; i++) run(int'($urandom_range(0, (1 << NB) - 1)), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
